// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two-requester ALU request bus plus shared response channel
interface alu_arbiter_if #(parameter int DW = 32);
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [DW-1:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic [3:0]    req0_ctrl, req1_ctrl;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [DW-1:0] result;
    logic          zero, cout, overflow, busy;
    modport slave (
        input  req0_valid, req1_valid, req0_src1, req0_src2, req1_src1, req1_src2,
        input  req0_ctrl, req1_ctrl, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, result, zero, cout, overflow, busy
    );
    modport master (
        output req0_valid, req1_valid, req0_src1, req0_src2, req1_src1, req1_src2,
        output req0_ctrl, req1_ctrl, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, result, zero, cout, overflow, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbitration of two requesters onto one ALU with a registered response
module alu_arbiter #(parameter int DW = 32) (
    input logic clk_i,
    input logic rst_i,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t        state_q, state_d;
    logic          rr_q, rr_d, id_q, id_d, rsp_id_q, rsp_id_d;
    logic [DW-1:0] src1_q, src1_d, src2_q, src2_d, result_q, result_d, alu_res;
    logic [3:0]    ctrl_q, ctrl_d;
    logic          rsp_valid_q, rsp_valid_d, zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;
    logic          grant1, accept, exec, alu_c, alu_v, ovf_add, ovf_sub;
    logic [DW:0]   sum, diff;

    // rr names the requester that wins when both are valid
    assign grant1         = bus.req1_valid & (~bus.req0_valid | rr_q);
    assign accept         = (state_q == IDLE) & ~rst_i & (bus.req0_valid | bus.req1_valid);
    assign exec           = state_q == EXEC;
    assign bus.req0_ready = accept & ~grant1;
    assign bus.req1_ready = accept & grant1;
    assign bus.busy       = state_q != IDLE;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.result     = result_q;
    assign bus.zero       = zero_q;
    assign bus.cout       = cout_q;
    assign bus.overflow   = ovf_q;

    always_comb begin
        sum     = {1'b0, src1_q} + {1'b0, src2_q};
        diff    = {1'b0, src1_q} + {1'b0, ~src2_q} + (DW+1)'(1);
        ovf_add = (src1_q[DW-1] == src2_q[DW-1]) & (sum[DW-1] != src1_q[DW-1]);
        ovf_sub = (src1_q[DW-1] != src2_q[DW-1]) & (diff[DW-1] != src1_q[DW-1]);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ctrl_q)
            4'b0000: alu_res = src1_q & src2_q;
            4'b0001: alu_res = src1_q | src2_q;
            4'b0010: {alu_c, alu_res, alu_v} = {sum, ovf_add};
            4'b0110: {alu_c, alu_res, alu_v} = {diff, ovf_sub};
            4'b1100: alu_res = ~(src1_q | src2_q);
            4'b1101: alu_res = ~(src1_q & src2_q);
            4'b0111: alu_res = {{(DW-1){1'b0}}, diff[DW-1] ^ ovf_sub};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = accept ? EXEC : exec ? RESP : (state_q == RESP && bus.rsp_ready) ? IDLE : state_q;
        rr_d        = accept ? ~grant1 : rr_q;
        id_d        = accept ? grant1 : id_q;
        src1_d      = accept ? (grant1 ? bus.req1_src1 : bus.req0_src1) : src1_q;
        src2_d      = accept ? (grant1 ? bus.req1_src2 : bus.req0_src2) : src2_q;
        ctrl_d      = accept ? (grant1 ? bus.req1_ctrl : bus.req0_ctrl) : ctrl_q;
        rsp_valid_d = exec | (rsp_valid_q & ~bus.rsp_ready);
        rsp_id_d    = exec ? id_q : rsp_id_q;
        result_d    = exec ? alu_res : result_q;
        zero_d      = exec ? (alu_res == '0) : zero_q;
        cout_d      = exec ? alu_c : cout_q;
        ovf_d       = exec ? alu_v : ovf_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            id_q        <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            ctrl_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            ctrl_q      <= ctrl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk_i  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  operation of requester 0/1 accepted this cycle.
REQ-006 SHALL have ports req0_src1, req0_src2, req1_src1, req1_src2  input  DW  operands.
REQ-007 SHALL have ports req0_ctrl / req1_ctrl  input  4  ALU control code.
REQ-008 SHALL have port rsp_valid  output  1  response registers hold a valid result.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-010 SHALL have port rsp_id  output  1  index of the requester that owns the response.
REQ-011 SHALL have ports result  output  DW, zero  output  1, cout  output  1, overflow  output  1  registered ALU outputs.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP; IDLE->EXEC on accept, EXEC->RESP unconditionally, RESP->IDLE on rsp_valid & rsp_ready.
REQ-014 SHALL drive reqN_ready combinationally high only in IDLE, only for the granted requester, at most one ready per cycle.
REQ-015 SHALL grant in IDLE: single valid -> that requester; both valid -> requester named by round-robin pointer rr (reset 0).
REQ-016 SHALL set rr to the non-granted index after every accept; rr unchanged when no accept occurs.
REQ-017 SHALL latch src1, src2, ctrl and requester index on accept; requester inputs are ignored in EXEC and RESP.
REQ-018 SHALL compute in EXEC and register outputs entering RESP; rsp_valid rises 2 cycles after the accept edge (accept at edge N, rsp_valid high after edge N+2).
REQ-019 SHALL decode ctrl: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (src1+~src2+1), 1100 NOR, 1101 NAND, 0111 SLT.
REQ-020 SHALL set cout to bit 32 of the 33-bit sum for ADD and SUB, 0 for all other codes.
REQ-021 SHALL set overflow for ADD when operand signs equal and result sign differs, for SUB when operand signs differ and result sign differs from src1; 0 otherwise.
REQ-022 SHALL set SLT result to {31'b0, diff[31] ^ ovf_sub} (signed compare, correct under overflow).
REQ-023 SHALL produce result 0, cout 0, overflow 0 for any undefined ctrl code.
REQ-024 SHALL set zero = (result == 0) for every code, including SLT and undefined codes.
REQ-025 SHALL hold result, zero, cout, overflow, rsp_id stable while rsp_valid & ~rsp_ready (backpressure, no limit on stall length).
REQ-026 SHALL not accept a new request in the cycle of the response handshake; minimum issue interval is 3 cycles.
REQ-027 SHALL keep outputs from the last response after RESP->IDLE, with rsp_valid low.

Reset
REQ-028 SHALL on rst_i high at a clock edge enter IDLE, clear rr, rsp_valid, rsp_id, result, zero, cout, overflow, busy to 0, regardless of state.
REQ-029 SHALL discard any in-flight operation when reset occurs in EXEC or RESP; no response issued for it.
REQ-030 SHALL hold req0_ready and req1_ready low while rst_i is high.

Verification
REQ-031 SHALL test: req0 ADD 0x7FFFFFFF+0x00000001, rsp_ready=1 -> ready at cycle N, rsp_valid at N+2, result 0x80000000, overflow 1, cout 0, zero 0, rsp_id 0.
REQ-032 SHALL test: req1 SUB 5-5 -> result 0, zero 1, cout 1, overflow 0, rsp_id 1.
REQ-033 SHALL test: req1 SLT 0x80000000 vs 0x00000001 -> result 1; then SLT 0x7FFFFFFF vs 0x80000000 -> result 0.
REQ-034 SHALL test: both valid continuously after reset -> grants 0,1,0,1, one accept every 3 cycles with rsp_ready=1.
REQ-035 SHALL test: rsp_ready low 10 cycles -> rsp_valid and outputs held constant, req ready low, release -> IDLE next cycle.
REQ-036 SHALL test: rst_i asserted in EXEC -> next cycle busy 0, rsp_valid 0, rr 0, no response for that operation; ctrl 1111 afterwards -> result 0, zero 1.
